lsu_mem_master: RTL and testbench

- Load/store initiator between the pipeline MEM stage and a word-organised, byte-lane data memory over a req/ack handshake.
- Decodes the access size, checks alignment, and generates byte enables plus lane-shifted write data.
- Waits for the memory acknowledge, then returns load data as a word, or as a sign- or zero-extended byte/halfword.
- Pipeline stalls on `cpu_busy`; `cpu_exc` feeds the exception unit.

---
 rtl/lsu_mem_master.sv | 180 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator: decodes size/alignment, drives a req/ack word memory port with byte
// enables and lane-replicated store data, and returns extended load data to the pipeline.
module lsu_mem_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic [1:0]        cpu_exc,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [1:0]        off_q, off_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_d, mem_we_d;
  logic [3:0]        mem_be_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d, cpu_rdata_d;
  logic              cpu_done_d;
  logic [1:0]        cpu_exc_d;

  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign cpu_ready = (state_q == StIdle) && !reset;
  assign cpu_busy  = (state_q != StIdle);

  assign misaligned = (cpu_size == 2'd2) ||
                      (cpu_size == 2'd1 && cpu_addr[0]) ||
                      (cpu_size == 2'd3 && cpu_addr[1:0] != 2'b00);

  // Halves are always even-aligned here, so one byte-granular shift serves all sizes.
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cpu_valid) state_d = misaligned ? StResp : StReq;
      StReq:   if (mem_ack || cnt_q == CntMax) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_rdata_d = cpu_rdata;
    cpu_done_d  = 1'b0;
    cpu_exc_d   = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (cpu_valid) begin
          size_d = cpu_size;
          uns_d  = cpu_unsigned;
          we_d   = cpu_we;
          off_d  = cpu_addr[1:0];
          cnt_d  = 8'd0;
          if (misaligned) begin
            cpu_done_d  = 1'b1;
            cpu_exc_d   = 2'b01;
            cpu_rdata_d = 32'd0;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = cpu_we;
            mem_addr_d = {cpu_addr[ADDR_W-1:2], 2'b00};
            unique case (cpu_size)
              2'd0: begin
                mem_be_d    = 4'b0001 << cpu_addr[1:0];
                mem_wdata_d = {4{cpu_wdata[7:0]}};
              end
              2'd1: begin
                mem_be_d    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{cpu_wdata[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = cpu_wdata;
              end
            endcase
          end
        end
      end
      StReq: begin
        if (mem_ack || cnt_q == CntMax) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b0000;
          cpu_done_d  = 1'b1;
          // Ack beats a coincident timeout.
          cpu_exc_d   = mem_ack ? 2'b00 : 2'b10;
          cpu_rdata_d = (mem_ack && !we_q) ? load_data : 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      off_q     <= 2'd0;
      cnt_q     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_rdata <= 32'd0;
      cpu_done  <= 1'b0;
      cpu_exc   <= 2'b00;
    end else begin
      size_q    <= size_d;
      uns_q     <= uns_d;
      we_q      <= we_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_be    <= mem_be_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_rdata <= cpu_rdata_d;
      cpu_done  <= cpu_done_d;
      cpu_exc   <= cpu_exc_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: stimulus pushes expected completions into a queue,
// a negedge monitor pops and compares them whenever cpu_done is seen.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic [1:0]  cpu_exc;
  logic        cpu_busy;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [33:0] exp_q[$];  // {rdata, exc}

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_valid    (cpu_valid),
    .cpu_ready    (cpu_ready),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_done     (cpu_done),
    .cpu_exc      (cpu_exc),
    .cpu_busy     (cpu_busy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("cpu_rdata", 64'(cpu_rdata), 64'(e[33:2]));
        chk("cpu_exc", 64'(cpu_exc), 64'(e[1:0]));
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    cpu_we       = we;
    cpu_size     = size;
    cpu_unsigned = uns;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    cpu_valid    = 1'b1;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
  endtask

  task automatic run_ok(input string nm, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] rdata, input logic [3:0] be,
                        input logic [31:0] maddr, input logic [31:0] mwdata,
                        input logic [31:0] exp_rdata);
    exp_q.push_back({exp_rdata, 2'b00});
    issue(we, size, uns, addr, wdata);
    for (int i = 1; i <= ack_dly; i++) begin
      @(negedge clk);
      chk({nm, "_req_we_be"}, 64'({mem_req, mem_we, mem_be}), 64'({1'b1, we, be}));
      chk({nm, "_addr"}, 64'(mem_addr), 64'(maddr));
      chk({nm, "_wdata"}, 64'(mem_wdata), 64'(mwdata));
      chk({nm, "_no_early_done"}, 64'(cpu_done), 64'd0);
      if (i == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
    end
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_done_after_ack"}, 64'(cpu_done), 64'd1);
    chk({nm, "_dropped"}, 64'({mem_req, mem_we, mem_be}), 64'd0);
    @(negedge clk);
    chk({nm, "_ready_again"}, 64'({cpu_ready, cpu_done}), 64'b10);
  endtask

  task automatic run_mis(input string nm, input logic [1:0] size, input logic [31:0] addr);
    exp_q.push_back({32'd0, 2'b01});
    issue(1'b0, size, 1'b0, addr, 32'h0);
    @(negedge clk);
    chk({nm, "_no_req"}, 64'(mem_req), 64'd0);
    chk({nm, "_done"}, 64'(cpu_done), 64'd1);
    @(negedge clk);
    chk({nm, "_no_req2"}, 64'({mem_req, cpu_done, cpu_ready}), 64'b001);
  endtask

  initial begin
    int cnt;
    bit seen;
    reset = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_unsigned = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({mem_req, mem_we, mem_be, cpu_done, cpu_exc, cpu_busy, cpu_ready}), 64'd0);
    chk("reset_data", 64'({mem_addr, cpu_rdata}), 64'd0);
    chk("reset_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;
    #1 chk("ready_after_reset", 64'(cpu_ready), 64'd1);

    run_ok("sw",  1'b1, 2'd3, 1'b0, 32'h104, 32'h11223344, 2, 32'hDEADBEEF, 4'b1111,
           32'h104, 32'h11223344, 32'h0);
    run_ok("sb",  1'b1, 2'd0, 1'b0, 32'h103, 32'h000000AB, 1, 32'hDEADBEEF, 4'b1000,
           32'h100, 32'hABABABAB, 32'h0);
    run_ok("sh",  1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 3, 32'hDEADBEEF, 4'b1100,
           32'h100, 32'hBEEFBEEF, 32'h0);
    run_ok("lb102",  1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 1, 32'h80FF7F00, 4'b0100,
           32'h100, 32'h0, 32'hFFFFFFFF);
    run_ok("lbu102", 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 2, 32'h80FF7F00, 4'b0100,
           32'h100, 32'h0, 32'h000000FF);
    run_ok("lb101",  1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 1, 32'h80FF7F00, 4'b0010,
           32'h100, 32'h0, 32'h0000007F);
    run_ok("lh102",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 3, 32'h80FF7F00, 4'b1100,
           32'h100, 32'h0, 32'hFFFF80FF);
    run_ok("lhu102", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1, 32'h80FF7F00, 4'b1100,
           32'h100, 32'h0, 32'h000080FF);
    run_ok("lw100",  1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 2, 32'h80FF7F00, 4'b1111,
           32'h100, 32'h0, 32'h80FF7F00);

    run_mis("mis_lh101", 2'd1, 32'h101);
    run_mis("mis_lw102", 2'd3, 32'h102);
    run_mis("mis_size2", 2'd2, 32'h100);

    // No ack at all: request must stay up exactly TIMEOUT cycles.
    exp_q.push_back({32'd0, 2'b10});
    issue(1'b0, 2'd3, 1'b0, 32'h200, 32'h0);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cpu_done) seen = 1'b1;
      else if (mem_req) cnt++;
    end
    chk("timeout_req_cycles", 64'(cnt), 64'd15);
    chk("timeout_done_seen", 64'(seen), 64'd1);
    @(negedge clk);

    run_ok("ack_at_limit", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 15, 32'h80FF7F00, 4'b1111,
           32'h100, 32'h0, 32'h80FF7F00);

    // Reset on the third REQ cycle: no completion may follow.
    issue(1'b0, 2'd3, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_req", 64'({mem_req, mem_be, cpu_busy, cpu_ready, cpu_done}), 64'd0);
    chk("midreset_rdata", 64'({mem_addr, cpu_rdata}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midreset_ready", 64'(cpu_ready), 64'd1);
    repeat (4) @(negedge clk);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
